ray_marcher: RTL and testbench



---
 rtl/ray_marcher_pkg.sv | 47 ++++
 rtl/ray_marcher_vec3_mac.sv | 38 +++
 rtl/ray_marcher.sv | 180 ++++++++++++++++++
 tb/tb_ray_marcher.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_marcher_pkg.sv
// Shared fixed-point math for the ray marcher: number format, vector type,
// FSM encoding and the arithmetic helpers used by the datapath.
package ray_marcher_pkg;

  localparam int BITS  = 32;
  localparam int FIXED = 16;

  typedef logic signed [BITS-1:0] fix_t;

  typedef struct packed {
    fix_t x;
    fix_t y;
    fix_t z;
  } vec3_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } state_t;

  // Truncates toward zero, so 0.01 becomes 655 at FIXED=16.
  function automatic fix_t to_fixed(input real r);
    return fix_t'($rtoi(r * (2.0 ** FIXED)));
  endfunction

  function automatic fix_t fix_mul(input fix_t a, input fix_t b);
    logic signed [2*BITS-1:0] a_w;
    logic signed [2*BITS-1:0] b_w;
    logic signed [2*BITS-1:0] prod;
    a_w  = a;
    b_w  = b;
    prod = (a_w * b_w) >>> FIXED;
    return prod[BITS-1:0];
  endfunction

  function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
    vec3_t s;
    s.x = a.x + b.x;
    s.y = a.y + b.y;
    s.z = a.z + b.z;
    return s;
  endfunction

endpackage

// File: rtl/ray_marcher_vec3_mac.sv
// Registered p + d*dir over three lanes; loads when enabled, otherwise holds.
module ray_marcher_vec3_mac
  import ray_marcher_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_n_in,
  input  logic  en_in,
  input  vec3_t p_in,
  input  vec3_t dir_in,
  input  fix_t  d_in,
  output vec3_t sum_out
);

  vec3_t sum_q;
  vec3_t sum_d;
  vec3_t step_v;

  always_comb begin
    step_v.x = fix_mul(d_in, dir_in.x);
    step_v.y = fix_mul(d_in, dir_in.y);
    step_v.z = fix_mul(d_in, dir_in.z);
    sum_d    = sum_q;
    if (en_in) begin
      sum_d = vec3_add(p_in, step_v);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/ray_marcher.sv
// Sphere-tracing controller: issues sample points to the SDF evaluator, marches
// along the ray by each returned distance and reports hit/miss with shading.
module ray_marcher
  import ray_marcher_pkg::*;
#(
  parameter int          MAX_STEPS   = 64,
  parameter fix_t        HIT_EPS     = to_fixed(0.01),
  parameter fix_t        MAX_DIST    = to_fixed(64.0),
  parameter int          SHADE_SHIFT = 2,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   ray_start,
  input  logic signed [BITS-1:0] ox_in,
  input  logic signed [BITS-1:0] oy_in,
  input  logic signed [BITS-1:0] oz_in,
  input  logic signed [BITS-1:0] dx_in,
  input  logic signed [BITS-1:0] dy_in,
  input  logic signed [BITS-1:0] dz_in,
  output logic                   ray_busy,
  output logic                   ray_done,
  output logic                   hit_out,
  output logic signed [BITS-1:0] depth_out,
  output logic [7:0]             steps_out,
  output logic [7:0]             red_out,
  output logic [7:0]             green_out,
  output logic [7:0]             blue_out,
  output logic                   sdf_start,
  output logic signed [BITS-1:0] sdf_x,
  output logic signed [BITS-1:0] sdf_y,
  output logic signed [BITS-1:0] sdf_z,
  input  logic                   sdf_done,
  input  logic signed [BITS-1:0] sdf_dist,
  input  logic [7:0]             sdf_red_in,
  input  logic [7:0]             sdf_green_in,
  input  logic [7:0]             sdf_blue_in
);

  localparam logic [7:0] MAX_STEPS_W = 8'(MAX_STEPS);

  state_t      state_q, state_d;
  vec3_t       p_q, p_d, dir_q, dir_d, mac_sum;
  fix_t        t_q, t_d, d_q, d_d, depth_q, depth_d, t_plus_d;
  logic [7:0]  steps_q, steps_d, steps_out_q, steps_out_d;
  logic [23:0] col_q, col_d, rgb_q, rgb_d;
  logic        hit_q, hit_d, hit_out_q, hit_out_d, done_q, done_d;
  logic        mac_en;

  function automatic logic [7:0] shade(input logic [7:0] c, input logic [7:0] steps);
    logic [15:0] dim;
    dim = 16'(steps) << SHADE_SHIFT;
    return (16'(c) > dim) ? 8'(16'(c) - dim) : 8'd0;
  endfunction

  assign t_plus_d = t_q + d_q;

  // The next sample point is computed while WAIT captures the distance, so it
  // is ready by the time ADVANCE decides to keep marching.
  ray_marcher_vec3_mac u_mac (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .en_in   (mac_en),
    .p_in    (p_q),
    .dir_in  (dir_q),
    .d_in    (sdf_dist),
    .sum_out (mac_sum)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    dir_d       = dir_q;
    t_d         = t_q;
    d_d         = d_q;
    steps_d     = steps_q;
    col_d       = col_q;
    hit_d       = hit_q;
    done_d      = 1'b0;
    hit_out_d   = hit_out_q;
    depth_d     = depth_q;
    steps_out_d = steps_out_q;
    rgb_d       = rgb_q;
    mac_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ray_start) begin
          p_d     = '{x: ox_in, y: oy_in, z: oz_in};
          dir_d   = '{x: dx_in, y: dy_in, z: dz_in};
          t_d     = '0;
          steps_d = '0;
          hit_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        steps_d = steps_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sdf_done) begin
          d_d     = sdf_dist;
          col_d   = {sdf_red_in, sdf_green_in, sdf_blue_in};
          mac_en  = 1'b1;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        state_d = S_FINISH;
        if (d_q < HIT_EPS) begin
          hit_d = 1'b1;
        end else if (steps_q == MAX_STEPS_W) begin
          hit_d = 1'b0;
        end else if (t_plus_d >= MAX_DIST) begin
          t_d = t_plus_d;
        end else begin
          t_d     = t_plus_d;
          p_d     = mac_sum;
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        done_d      = 1'b1;
        hit_out_d   = hit_q;
        depth_d     = t_q;
        steps_out_d = steps_q;
        rgb_d       = hit_q ? {shade(col_q[23:16], steps_q), shade(col_q[15:8], steps_q),
                               shade(col_q[7:0], steps_q)} : BG_COLOR;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      dir_q       <= '0;
      t_q         <= '0;
      d_q         <= '0;
      steps_q     <= '0;
      col_q       <= '0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      hit_out_q   <= 1'b0;
      depth_q     <= '0;
      steps_out_q <= '0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      dir_q       <= dir_d;
      t_q         <= t_d;
      d_q         <= d_d;
      steps_q     <= steps_d;
      col_q       <= col_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      hit_out_q   <= hit_out_d;
      depth_q     <= depth_d;
      steps_out_q <= steps_out_d;
      rgb_q       <= rgb_d;
    end
  end

  assign ray_busy  = (state_q != S_IDLE);
  assign ray_done  = done_q;
  assign sdf_start = (state_q == S_ISSUE);
  assign sdf_x     = p_q.x;
  assign sdf_y     = p_q.y;
  assign sdf_z     = p_q.z;
  assign hit_out   = hit_out_q;
  assign depth_out = depth_q;
  assign steps_out = steps_out_q;
  assign red_out   = rgb_q[23:16];
  assign green_out = rgb_q[15:8];
  assign blue_out  = rgb_q[7:0];

endmodule

// File: tb/tb_ray_marcher.sv
// Bench for ray_marcher: two instances (MAX_DIST 64.0 and 16.0) driven by a
// scripted 3-cycle SDF stub, checked against a loop-level marching model.
module tb_ray_marcher;
  import ray_marcher_pkg::*;

  localparam int   N          = 2;
  localparam int   SDF_LAT    = 3;
  localparam int   MAXS       = 64;
  localparam int   WAIT_LIMIT = 2000;
  localparam int   ONE_I      = 65536;
  localparam fix_t ONE        = 32'sh0001_0000;
  localparam fix_t EPS        = 32'sd655;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       ray_start [N];
  fix_t       ox, oy, oz, dx, dy, dz;
  logic       ray_busy [N];
  logic       ray_done [N];
  logic       hit_out [N];
  fix_t       depth_out [N];
  logic [7:0] steps_out [N];
  logic [7:0] red_out [N];
  logic [7:0] green_out [N];
  logic [7:0] blue_out [N];
  logic       sdf_start [N];
  fix_t       sdf_x [N];
  fix_t       sdf_y [N];
  fix_t       sdf_z [N];
  logic       sdf_done [N];
  fix_t       sdf_dist [N];
  logic [7:0] sdf_r, sdf_g, sdf_b;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    ray_marcher #(
      .MAX_DIST(gi == 0 ? 32'sh0040_0000 : 32'sh0010_0000)
    ) u_dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .ray_start   (ray_start[gi]),
      .ox_in       (ox),
      .oy_in       (oy),
      .oz_in       (oz),
      .dx_in       (dx),
      .dy_in       (dy),
      .dz_in       (dz),
      .ray_busy    (ray_busy[gi]),
      .ray_done    (ray_done[gi]),
      .hit_out     (hit_out[gi]),
      .depth_out   (depth_out[gi]),
      .steps_out   (steps_out[gi]),
      .red_out     (red_out[gi]),
      .green_out   (green_out[gi]),
      .blue_out    (blue_out[gi]),
      .sdf_start   (sdf_start[gi]),
      .sdf_x       (sdf_x[gi]),
      .sdf_y       (sdf_y[gi]),
      .sdf_z       (sdf_z[gi]),
      .sdf_done    (sdf_done[gi]),
      .sdf_dist    (sdf_dist[gi]),
      .sdf_red_in  (sdf_r),
      .sdf_green_in(sdf_g),
      .sdf_blue_in (sdf_b)
    );
  end

  // Scripted SDF: the k-th sample of a ray gets script[k], the last entry repeats.
  fix_t  script [N][128];
  int    script_len [N];
  vec3_t samples [N][128];
  int    nsamp [N];
  int    cd [N];
  fix_t  pend [N];
  int    done_cnt [N];
  vec3_t exp_pts [128];

  function automatic fix_t script_at(input int i, input int k);
    int j;
    j = (k < script_len[i]) ? k : script_len[i] - 1;
    if (j < 0) j = 0;
    if (j > 127) j = 127;
    return script[i][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      sdf_done[i] <= 1'b0;
      if (ray_done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      if (rst_n === 1'b1 && ray_start[i] === 1'b1 && ray_busy[i] === 1'b0) nsamp[i] <= 0;
      if (cd[i] == 1) begin
        sdf_done[i] <= 1'b1;
        sdf_dist[i] <= pend[i];
      end
      if (cd[i] != 0) cd[i] <= cd[i] - 1;
      if (sdf_start[i] === 1'b1) begin
        samples[i][nsamp[i] & 127] <= '{x: sdf_x[i], y: sdf_y[i], z: sdf_z[i]};
        pend[i]  <= script_at(i, nsamp[i]);
        nsamp[i] <= nsamp[i] + 1;
        cd[i]    <= SDF_LAT;
      end
    end
  end

  int total, bad;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic fix_t fmul(input fix_t a, input fix_t b);
    longint pr;
    pr = longint'(a) * longint'(b);
    return fix_t'(pr >>> 16);
  endfunction

  function automatic logic [7:0] shade(input logic [7:0] c, input int steps);
    int v;
    v = int'(c) - steps * 4;
    return (v < 0) ? 8'd0 : 8'(v);
  endfunction

  // Marches the ray with plain arithmetic, recording every expected sample point.
  task automatic model(input int inst, input vec3_t o, input vec3_t dv,
                       output bit hit, output fix_t t, output int steps);
    fix_t  maxd;
    fix_t  d;
    vec3_t p;
    maxd  = (inst == 0) ? 32'sh0040_0000 : 32'sh0010_0000;
    p     = o;
    t     = '0;
    steps = 0;
    hit   = 1'b0;
    for (int k = 0; k < MAXS; k++) begin
      steps      = k + 1;
      exp_pts[k] = p;
      d          = script_at(inst, k);
      if (d < EPS) begin
        hit = 1'b1;
        break;
      end
      if (steps == MAXS) break;
      if (fix_t'(t + d) >= maxd) begin
        t = t + d;
        break;
      end
      t   = t + d;
      p.x = p.x + fmul(d, dv.x);
      p.y = p.y + fmul(d, dv.y);
      p.z = p.z + fmul(d, dv.z);
    end
  endtask

  task automatic check_ray(input int inst, input vec3_t o, input vec3_t dv, input string tag);
    bit          hit;
    fix_t        t;
    int          steps;
    logic [23:0] rgb;
    model(inst, o, dv, hit, t, steps);
    rgb = hit ? {shade(sdf_r, steps), shade(sdf_g, steps), shade(sdf_b, steps)} : 24'h0;
    check_eq({tag, ".hit"}, hit_out[inst], hit);
    check_eq({tag, ".depth"}, depth_out[inst], t);
    check_eq({tag, ".steps"}, steps_out[inst], steps);
    check_eq({tag, ".rgb"}, {red_out[inst], green_out[inst], blue_out[inst]}, rgb);
    check_eq({tag, ".nsamp"}, nsamp[inst], steps);
    for (int k = 0; k < steps && k < 128; k++)
      check_eq($sformatf("%s.pt%0d", tag, k), samples[inst][k], exp_pts[k]);
    $display("ray %s inst=%0d hit=%0b steps=%0d depth=%h rgb=%h", tag, inst,
             hit_out[inst], steps_out[inst], depth_out[inst],
             {red_out[inst], green_out[inst], blue_out[inst]});
  endtask

  // Called just after a negedge; the request is seen at the following posedge.
  task automatic start_ray(input int inst, input vec3_t o, input vec3_t dv, input string tag);
    ox = o.x;  oy = o.y;  oz = o.z;
    dx = dv.x; dy = dv.y; dz = dv.z;
    ray_start[inst] = 1'b1;
    @(negedge clk);
    ray_start[inst] = 1'b0;
    check_eq({tag, ".busy"}, ray_busy[inst], 1'b1);
  endtask

  task automatic wait_done(input int inst, input string tag);
    int n;
    n = 0;
    while (ray_done[inst] !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".in_time"}, n < WAIT_LIMIT, 1'b1);
  endtask

  task automatic check_zero(input int inst, input string tag);
    check_eq({tag, ".ctl"}, {ray_busy[inst], ray_done[inst], hit_out[inst], depth_out[inst],
             steps_out[inst], red_out[inst], green_out[inst], blue_out[inst], sdf_start[inst]}, '0);
    check_eq({tag, ".pt"}, {sdf_x[inst], sdf_y[inst], sdf_z[inst]}, '0);
  endtask

  function automatic vec3_t rand_vec(input int span);
    vec3_t v;
    v.x = fix_t'($urandom_range(0, 2 * span * ONE_I)) - fix_t'(span * ONE_I);
    v.y = fix_t'($urandom_range(0, 2 * span * ONE_I)) - fix_t'(span * ONE_I);
    v.z = fix_t'($urandom_range(0, 2 * span * ONE_I)) - fix_t'(span * ONE_I);
    return v;
  endfunction

  function automatic fix_t rand_dist();
    if ($urandom_range(0, 9) == 0) return fix_t'($urandom_range(0, 1000)) - 32'sd500;
    return fix_t'($urandom_range(700, 6 * ONE_I));
  endfunction

  initial begin
    vec3_t o, dv, o2;
    int    dc;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      ray_start[i]  = 1'b0;
      script[i][0]  = '0;
      script_len[i] = 1;
    end
    ox = '0; oy = '0; oz = '0; dx = '0; dy = '0; dz = '0;
    sdf_r = 8'hF0; sdf_g = 8'h00; sdf_b = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check_zero(i, $sformatf("rst_init%0d", i));
    rst_n = 1'b1;
    @(negedge clk);

    // Two-step hit: second sample at z=-3.0
    script[0][0] = 2 * ONE; script[0][1] = '0; script_len[0] = 2;
    o  = '{x: 32'sd0, y: 32'sd0, z: -5 * ONE};
    dv = '{x: 32'sd0, y: 32'sd0, z: ONE};
    start_ray(0, o, dv, "hit2");
    wait_done(0, "hit2");
    check_ray(0, o, dv, "hit2");
    check_eq("hit2.depth_abs", depth_out[0], 32'h0002_0000);
    check_eq("hit2.z2_abs", samples[0][1].z, -3 * ONE);
    check_eq("hit2.rgb_abs", {red_out[0], green_out[0], blue_out[0]}, 24'hE80000);

    // Reset mid-WAIT: outputs clear, the late sdf_done is ignored, no ray_done
    script[0][0] = 2 * ONE; script_len[0] = 1;
    start_ray(0, o, dv, "rst");
    check_eq("rst.issue", sdf_start[0], 1'b1);
    @(negedge clk);
    dc = done_cnt[0];
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero(0, "rst_mid");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_zero(0, "rst_late");
    check_eq("rst.no_done", done_cnt[0], dc);

    // Constant 1.0 against MAX_DIST 16.0: miss with t reaching exactly 16.0
    script[1][0] = ONE; script_len[1] = 1;
    o  = '{x: ONE, y: 32'sd0, z: 32'sd0};
    dv = '{x: 32'sd0, y: ONE, z: 32'sd0};
    start_ray(1, o, dv, "miss16");
    wait_done(1, "miss16");
    check_ray(1, o, dv, "miss16");
    check_eq("miss16.depth_abs", depth_out[1], 32'h0010_0000);
    check_eq("miss16.steps_abs", steps_out[1], 8'd16);

    // Constant 0.25: step budget exhausted after 63 advances
    script[0][0] = ONE / 4; script_len[0] = 1;
    start_ray(0, o, dv, "max64");
    wait_done(0, "max64");
    check_ray(0, o, dv, "max64");
    check_eq("max64.depth_abs", depth_out[0], 32'h000F_C000);
    check_eq("max64.steps_abs", steps_out[0], 8'd64);

    // Negative first distance is a hit on the origin
    script[0][0] = -ONE / 2; script_len[0] = 1;
    start_ray(0, o, dv, "neg");
    wait_done(0, "neg");
    check_ray(0, o, dv, "neg");
    check_eq("neg.depth_abs", depth_out[0], 32'h0);
    check_eq("neg.steps_abs", steps_out[0], 8'd1);

    // Hit threshold boundary: exactly EPS marches on, EPS-1 hits
    script[0][0] = EPS; script[0][1] = EPS - 1; script_len[0] = 2;
    start_ray(0, o, dv, "eps");
    wait_done(0, "eps");
    check_ray(0, o, dv, "eps");
    check_eq("eps.depth_abs", depth_out[0], 32'sd655);

    // A start mid-ray is ignored; a start during ray_done is accepted
    script[0][0] = ONE; script[0][1] = ONE; script[0][2] = ONE; script[0][3] = '0;
    script_len[0] = 4;
    start_ray(0, o, dv, "ign");
    repeat (5) @(negedge clk);
    o2 = '{x: 7 * ONE, y: 7 * ONE, z: 7 * ONE};
    ox = o2.x; oy = o2.y; oz = o2.z;
    ray_start[0] = 1'b1;
    @(negedge clk);
    ray_start[0] = 1'b0;
    wait_done(0, "ign");
    check_ray(0, o, dv, "ign");
    script[0][0] = ONE / 2; script[0][1] = '0; script_len[0] = 2;
    start_ray(0, o2, dv, "b2b");
    wait_done(0, "b2b");
    check_ray(0, o2, dv, "b2b");

    // Randomized rays, sometimes back-to-back
    for (int r = 0; r < 24; r++) begin
      int inst;
      int len;
      inst = $urandom_range(0, 1);
      len  = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) script[inst][k] = rand_dist();
      script_len[inst] = len;
      sdf_r = 8'($urandom); sdf_g = 8'($urandom); sdf_b = 8'($urandom);
      o  = rand_vec(8);
      dv = rand_vec(1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      start_ray(inst, o, dv, $sformatf("rnd%0d", r));
      wait_done(inst, $sformatf("rnd%0d", r));
      check_ray(inst, o, dv, $sformatf("rnd%0d", r));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
